// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the two byte requesters, the arbiter and the shared uart_tx.
// The slave side is the arbiter; the master side is the requesters plus uart_tx.
interface uart_tx_arbiter_if;
  logic [1:0] i_Req;
  logic [7:0] i_Byte0;
  logic [7:0] i_Byte1;
  logic [1:0] i_Last;
  logic [1:0] o_Ack;
  logic [1:0] o_Grant;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Done;
  logic       i_TX_Active;
  logic       o_Busy;
  logic       o_Timeout;

  modport slave (
    input  i_Req, i_Byte0, i_Byte1, i_Last, i_TX_Done, i_TX_Active,
    output o_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout
  );

  modport master (
    output i_Req, i_Byte0, i_Byte1, i_Last, i_TX_Done, i_TX_Active,
    input  o_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between two byte requesters, with packet
// locking and a watchdog for lost done pulses and abandoned locks.
module uart_tx_arbiter #(
  parameter int c_TIMEOUT_CLKS = 2604
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

  localparam logic [15:0] WD_LAST = 16'(c_TIMEOUT_CLKS - 1);

  state_t      state;
  logic        sel;
  logic        ptr;
  logic        locked;
  logic        last_q;
  logic [7:0]  byte_q;
  logic [15:0] wdog;
  logic        pick;
  logic        pick_vld;
  logic        unused_active;

  // uart_tx activity is informational only; the FSM paces itself on done.
  assign unused_active = bus.i_TX_Active;

  function automatic logic [1:0] onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    if (locked) begin
      pick     = sel;
      pick_vld = bus.i_Req[sel];
    end else if (bus.i_Req[ptr]) begin
      pick_vld = 1'b1;
    end else if (bus.i_Req[~ptr]) begin
      pick     = ~ptr;
      pick_vld = 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      sel           <= 1'b0;
      ptr           <= 1'b0;
      locked        <= 1'b0;
      last_q        <= 1'b0;
      byte_q        <= '0;
      wdog          <= '0;
      bus.o_Ack     <= '0;
      bus.o_Grant   <= '0;
      bus.o_TX_DV   <= 1'b0;
      bus.o_TX_Byte <= '0;
      bus.o_Busy    <= 1'b0;
      bus.o_Timeout <= 1'b0;
    end else begin
      bus.o_TX_DV   <= 1'b0;
      bus.o_Ack     <= '0;
      bus.o_Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            sel         <= pick;
            byte_q      <= pick ? bus.i_Byte1 : bus.i_Byte0;
            last_q      <= bus.i_Last[pick];
            bus.o_Grant <= onehot(pick);
            bus.o_Busy  <= 1'b1;
            wdog        <= '0;
            state       <= LOAD;
          end else if (locked) begin
            // Owner went quiet mid-packet: release the lock after the budget.
            if (wdog == WD_LAST) begin
              bus.o_Timeout <= 1'b1;
              locked        <= 1'b0;
              ptr           <= ~sel;
              bus.o_Grant   <= '0;
              wdog          <= '0;
            end else begin
              wdog <= wdog + 16'd1;
            end
          end else begin
            wdog <= '0;
          end
        end
        LOAD: begin
          bus.o_TX_DV   <= 1'b1;
          bus.o_TX_Byte <= byte_q;
          bus.o_Ack     <= onehot(sel);
          if (last_q) begin
            locked <= 1'b0;
            ptr    <= ~sel;
          end else begin
            locked <= 1'b1;
          end
          wdog  <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done arriving on the expiry cycle still wins over the timeout.
          if (bus.i_TX_Done) begin
            wdog  <= '0;
            state <= GAP;
          end else if (wdog == WD_LAST) begin
            bus.o_Timeout <= 1'b1;
            locked        <= 1'b0;
            ptr           <= ~sel;
            bus.o_Grant   <= '0;
            bus.o_Busy    <= 1'b0;
            wdog          <= '0;
            state         <= IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        GAP: begin
          bus.o_Busy <= 1'b0;
          if (!locked) bus.o_Grant <= '0;
          wdog  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx, two queued requesters and a
// scoreboard of {grant, byte} expected in transmit order.
module tb_uart_tx_arbiter;

  localparam int TO = 20;

  logic i_Clock = 1'b0;
  logic i_Rst_L = 1'b0;
  always #5 i_Clock = ~i_Clock;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.c_TIMEOUT_CLKS(TO)) dut (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
  logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
  logic       done_r = 1'b0;
  logic       tx_busy = 1'b0;
  bit         done_en = 1'b1;
  int         tx_cnt = 0;
  int         tx_clks = 12;

  assign bus.i_Req       = {req1, req0};
  assign bus.i_Byte0     = byte0;
  assign bus.i_Byte1     = byte1;
  assign bus.i_Last      = {last1, last0};
  assign bus.i_TX_Done   = done_r;
  assign bus.i_TX_Active = tx_busy;

  typedef struct packed {
    logic       last;
    logic [7:0] b;
  } item_t;

  item_t      pend0[$];
  item_t      pend1[$];
  logic [9:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  int n_to  = 0;
  bit dv_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, n_cyc);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.o_Ack, bus.o_Grant, bus.o_TX_DV, bus.o_TX_Byte, bus.o_Busy, bus.o_Timeout};
  endfunction

  function automatic bit quiet();
    return !bus.o_Busy && pend0.size() == 0 && pend1.size() == 0 && !req0 && !req1 &&
           !tx_busy && exp_q.size() == 0;
  endfunction

  task automatic offer(input bit ch, input logic [7:0] b, input logic l);
    item_t it;
    it.last = l;
    it.b    = b;
    if (ch) pend1.push_back(it);
    else    pend0.push_back(it);
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
  endtask

  // One clock: uart_tx model, scoreboard on the strobe, requester handshakes.
  task automatic tick();
    logic [9:0] e;
    @(posedge i_Clock);
    #1;
    n_cyc++;
    done_r = 1'b0;
    if (tx_busy) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy = 1'b0;
        done_r  = done_en;
      end
    end
    if (bus.o_TX_DV) begin
      dv_seen = 1'b1;
      chk("ack_with_dv", 32'(bus.o_Ack), 32'(bus.o_Grant));
      chk("busy_in_tx", 32'(bus.o_Busy), 32'd1);
      if (exp_q.size() == 0) begin
        chk("sb_extra_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("tx_grant_byte", 32'({bus.o_Grant, bus.o_TX_Byte}), 32'(e));
      end
      tx_busy = 1'b1;
      tx_cnt  = tx_clks;
    end
    if (bus.o_Timeout) n_to++;
    if (bus.o_Ack[0]) begin
      chk("ack0_req", 32'(req0), 32'd1);
      if (pend0.size() != 0) pend0.delete(0);
      req0 = 1'b0;
    end else if (!req0 && pend0.size() != 0 && i_Rst_L) begin
      req0  = 1'b1;
      byte0 = pend0[0].b;
      last0 = pend0[0].last;
    end
    if (bus.o_Ack[1]) begin
      chk("ack1_req", 32'(req1), 32'd1);
      if (pend1.size() != 0) pend1.delete(0);
      req1 = 1'b0;
    end else if (!req1 && pend1.size() != 0 && i_Rst_L) begin
      req1  = 1'b1;
      byte1 = pend1[0].b;
      last1 = pend1[0].last;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!quiet() && n < 2000);
    chk("drain", 32'(quiet()), 32'd1);
    chk("grant_free", 32'(bus.o_Grant), 32'd0);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 200 && tx_busy; i++) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time: bench did not finish, n_cyc=%0d", n_cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int to0;
    int st;
    bit prevb;

    repeat (2) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    i_Rst_L = 1'b1;
    tick();

    // Lone byte: strobe and ack one cycle after the grant edge.
    offer(1'b0, 8'h3F, 1'b1);
    expect_tx(2'b01, 8'h3F);
    tick();
    tick();
    chk("t1_grant", 32'(bus.o_Grant), 32'h1);
    chk("t1_dv_early", 32'(bus.o_TX_DV), 32'd0);
    tick();
    chk("t1_dv", 32'(bus.o_TX_DV), 32'd1);
    chk("t1_ack", 32'(bus.o_Ack), 32'h1);
    drain();

    // ptr now points at channel 1, so a tie goes to channel 1 first.
    offer(1'b0, 8'hA5, 1'b1);
    offer(1'b1, 8'h5A, 1'b1);
    expect_tx(2'b10, 8'h5A);
    expect_tx(2'b01, 8'hA5);
    drain();

    i_Rst_L = 1'b0;
    tick();
    i_Rst_L = 1'b1;
    tick();

    offer(1'b0, 8'hA5, 1'b1);
    offer(1'b1, 8'h5A, 1'b1);
    expect_tx(2'b01, 8'hA5);
    expect_tx(2'b10, 8'h5A);
    drain();
    offer(1'b0, 8'h11, 1'b1);
    offer(1'b1, 8'h22, 1'b1);
    expect_tx(2'b01, 8'h11);
    expect_tx(2'b10, 8'h22);
    drain();

    // Locked packet is not interleaved by the waiting channel.
    offer(1'b0, 8'h01, 1'b0);
    offer(1'b0, 8'h02, 1'b0);
    offer(1'b0, 8'h03, 1'b1);
    offer(1'b1, 8'h77, 1'b1);
    expect_tx(2'b01, 8'h01);
    expect_tx(2'b01, 8'h02);
    expect_tx(2'b01, 8'h03);
    expect_tx(2'b10, 8'h77);
    drain();

    // Missing done: watchdog fires TO cycles after entering WAIT_DONE.
    done_en = 1'b0;
    dv_seen = 1'b0;
    offer(1'b0, 8'h5C, 1'b1);
    expect_tx(2'b01, 8'h5C);
    for (int i = 0; i < 50 && !dv_seen; i++) tick();
    to0 = n_to;
    n   = 0;
    while (n_to == to0 && n < 100) begin
      tick();
      n++;
    end
    chk("wd_latency", 32'(n), 32'(TO));
    chk("wd_grant", 32'(bus.o_Grant), 32'd0);
    chk("wd_busy", 32'(bus.o_Busy), 32'd0);
    wait_tx_idle();
    done_en = 1'b1;
    drain();

    // Done landing on the expiry cycle counts as done.
    tx_clks = TO - 1;
    to0 = n_to;
    offer(1'b1, 8'hC3, 1'b1);
    expect_tx(2'b10, 8'hC3);
    drain();
    chk("done_beats_timeout", 32'(n_to - to0), 32'd0);
    tx_clks = 12;

    // Abandoned lock by channel 1 blocks channel 0 until the watchdog.
    offer(1'b1, 8'h10, 1'b0);
    expect_tx(2'b10, 8'h10);
    expect_tx(2'b01, 8'h20);
    for (int i = 0; i < 50 && pend1.size() != 0; i++) tick();
    offer(1'b0, 8'h20, 1'b1);
    to0   = n_to;
    prevb = 1'b1;
    st    = n_cyc;
    for (int i = 0; i < 500 && n_to == to0; i++) begin
      tick();
      if (prevb && !bus.o_Busy) st = n_cyc;
      prevb = bus.o_Busy;
    end
    chk("lock_to_latency", 32'(n_cyc - st), 32'(TO));
    chk("lock_to_grant", 32'(bus.o_Grant), 32'd0);
    chk("lock_ch0_blocked", 32'(pend0.size()), 32'd1);
    drain();
    chk("lock_to_count", 32'(n_to - to0), 32'd1);

    // Reset in WAIT_DONE clears outputs at once and restores ptr=0.
    dv_seen = 1'b0;
    offer(1'b0, 8'h66, 1'b1);
    expect_tx(2'b01, 8'h66);
    for (int i = 0; i < 50 && !dv_seen; i++) tick();
    tick();
    tick();
    chk("pre_rst_busy", 32'(bus.o_Busy), 32'd1);
    i_Rst_L = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    repeat (3) tick();
    chk("rst_hold", 32'(outs()), 32'd0);
    i_Rst_L = 1'b1;
    wait_tx_idle();
    offer(1'b0, 8'h44, 1'b1);
    offer(1'b1, 8'h99, 1'b1);
    expect_tx(2'b01, 8'h44);
    expect_tx(2'b10, 8'h99);
    drain();
    offer(1'b1, 8'hE7, 1'b1);
    expect_tx(2'b10, 8'hE7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
